// File: rtl/dcache_load_arbiter.sv
// Shares one D-cache load port between the CPU load unit and the stride prefetcher.
// Optional build macro: DCACHE_ARB_PF_KILL_EN (CPU demand kills an in-flight prefetch).
package dcache_load_arbiter_pkg;
  typedef struct packed {
    logic [11:0] address_index;
    logic [19:0] address_tag;
    logic [31:0] data_wdata;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [1:0]  data_size;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
  } dcache_req_o_t;
endpackage

module dcache_load_arbiter
  import dcache_load_arbiter_pkg::*;
#(
  parameter int unsigned IdleThres = 4
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  dcache_req_i_t cpu_req_i,
  output dcache_req_o_t cpu_rsp_o,
  input  dcache_req_i_t pf_req_i,
  output dcache_req_o_t pf_rsp_o,
  output dcache_req_i_t cache_req_o,
  input  dcache_req_o_t cache_rsp_i,
  output logic [31:0]   pf_grant_cnt_o,
  output logic [31:0]   pf_kill_cnt_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_TAG       = 2'd1;
  localparam logic [1:0] S_WAIT_RVAL = 2'd2;

  logic [1:0]  r_state;
  logic        r_owner_pf;
  logic [7:0]  r_idle_cnt;
  logic [31:0] r_pf_grant_cnt;

  logic [1:0]  w_state_next;
  logic        w_owner_next;
  logic        w_busy;
  logic        w_open;
  logic        w_pf_eligible;
  logic        w_sel_cpu;
  logic        w_sel_pf;
  logic        w_grant;
  logic        w_kill_now;
  logic        w_pf_rdata_zero;
  logic        w_unused_pf_we;

  dcache_req_i_t w_owner_req;

  assign w_busy        = (r_state == S_TAG) || (r_state == S_WAIT_RVAL);
  assign w_open        = (r_state == S_IDLE) || cache_rsp_i.data_rvalid;
  assign w_pf_eligible = ({24'd0, r_idle_cnt} >= IdleThres);
  assign w_sel_cpu     = w_open && cpu_req_i.data_req;
  assign w_sel_pf      = w_open && !cpu_req_i.data_req && pf_req_i.data_req && w_pf_eligible;
  assign w_grant       = cache_rsp_i.data_gnt && (w_sel_cpu || w_sel_pf);
  assign w_owner_req   = r_owner_pf ? pf_req_i : cpu_req_i;
  // Prefetch writes are never legal on this port; its data_we is ignored.
  assign w_unused_pf_we = pf_req_i.data_we;

`ifdef DCACHE_ARB_PF_KILL_EN
  logic        r_killed;
  logic [31:0] r_pf_kill_cnt;

  assign w_kill_now      = w_busy && r_owner_pf && cpu_req_i.data_req;
  assign w_pf_rdata_zero = w_kill_now || r_killed;
  assign pf_kill_cnt_o   = r_pf_kill_cnt;

  // One count per killed transaction; the flag lives until that transaction's rvalid.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_killed      <= 1'b0;
      r_pf_kill_cnt <= '0;
    end else begin
      if (w_kill_now && !r_killed) r_pf_kill_cnt <= r_pf_kill_cnt + 32'd1;
      if (w_busy && cache_rsp_i.data_rvalid) r_killed <= 1'b0;
      else if (w_kill_now)                   r_killed <= 1'b1;
    end
  end
`else
  assign w_kill_now      = 1'b0;
  assign w_pf_rdata_zero = 1'b0;
  assign pf_kill_cnt_o   = '0;
`endif

  assign pf_grant_cnt_o = r_pf_grant_cnt;

  always_comb begin
    cache_req_o = '0;
    if (!rst_ni) begin
      // While held in reset only the CPU address/request path flows through.
      cache_req_o.data_req      = cpu_req_i.data_req;
      cache_req_o.address_index = cpu_req_i.address_index;
    end else begin
      if (w_sel_cpu) begin
        cache_req_o.address_index = cpu_req_i.address_index;
        cache_req_o.data_req      = 1'b1;
        cache_req_o.data_we       = cpu_req_i.data_we;
        cache_req_o.data_be       = cpu_req_i.data_be;
        cache_req_o.data_size     = cpu_req_i.data_size;
        cache_req_o.data_wdata    = cpu_req_i.data_wdata;
      end else if (w_sel_pf) begin
        cache_req_o.address_index = pf_req_i.address_index;
        cache_req_o.data_req      = 1'b1;
        cache_req_o.data_be       = pf_req_i.data_be;
        cache_req_o.data_size     = pf_req_i.data_size;
        cache_req_o.data_wdata    = pf_req_i.data_wdata;
      end
      if (w_busy) begin
        cache_req_o.address_tag = w_owner_req.address_tag;
        cache_req_o.tag_valid   = w_owner_req.tag_valid;
        cache_req_o.kill_req    = w_owner_req.kill_req | w_kill_now;
      end
    end
  end

  always_comb begin
    cpu_rsp_o = '0;
    pf_rsp_o  = '0;
    if (rst_ni) begin
      cpu_rsp_o.data_gnt = cache_rsp_i.data_gnt && w_sel_cpu;
      pf_rsp_o.data_gnt  = cache_rsp_i.data_gnt && w_sel_pf;
      if (w_busy && !r_owner_pf) begin
        cpu_rsp_o.data_rvalid = cache_rsp_i.data_rvalid;
        cpu_rsp_o.data_rdata  = cache_rsp_i.data_rdata;
      end
      if (w_busy && r_owner_pf) begin
        pf_rsp_o.data_rvalid = cache_rsp_i.data_rvalid;
        pf_rsp_o.data_rdata  = w_pf_rdata_zero ? 32'd0 : cache_rsp_i.data_rdata;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner_pf;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_next = S_TAG;
          w_owner_next = w_sel_pf;
        end
      end
      S_TAG, S_WAIT_RVAL: begin
        if (cache_rsp_i.data_rvalid) begin
          if (w_grant) begin
            w_state_next = S_TAG;
            w_owner_next = w_sel_pf;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_WAIT_RVAL;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_IDLE;
      r_owner_pf     <= 1'b0;
      r_idle_cnt     <= '0;
      r_pf_grant_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_owner_pf <= w_owner_next;
      if (cpu_req_i.data_req || (w_busy && !r_owner_pf)) r_idle_cnt <= '0;
      else if (r_idle_cnt != 8'hFF)                       r_idle_cnt <= r_idle_cnt + 8'd1;
      if (cache_rsp_i.data_gnt && w_sel_pf) r_pf_grant_cnt <= r_pf_grant_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_dcache_load_arbiter.sv
// Bench for dcache_load_arbiter: directed scenarios then random traffic against a
// transaction-level model (busy flag + owner + idle-cycle count).
module tb_dcache_load_arbiter;
  import dcache_load_arbiter_pkg::*;

  localparam int IDLE_THRES = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  dcache_req_i_t cpu_req, pf_req, cache_req;
  dcache_req_o_t cpu_rsp, pf_rsp, cache_rsp;
  logic [31:0]   pf_grant_cnt, pf_kill_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one outstanding transaction at most, plus its owner.
  bit          m_busy, m_owner_pf, m_killed;
  int          m_idle, m_sel;
  logic [31:0] m_gcnt, m_kcnt;
  bit          kill_exp;

  dcache_load_arbiter #(.IdleThres(IDLE_THRES)) dut (
    .clk           (clk),
    .rst_ni        (rst_ni),
    .cpu_req_i     (cpu_req),
    .cpu_rsp_o     (cpu_rsp),
    .pf_req_i      (pf_req),
    .pf_rsp_o      (pf_rsp),
    .cache_req_o   (cache_req),
    .cache_rsp_i   (cache_rsp),
    .pf_grant_cnt_o(pf_grant_cnt),
    .pf_kill_cnt_o (pf_kill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit kill_now();
`ifdef DCACHE_ARB_PF_KILL_EN
    return m_busy && m_owner_pf && cpu_req.data_req;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void m_reset();
    m_busy = 0; m_owner_pf = 0; m_killed = 0; m_idle = 0; m_sel = 0;
    m_gcnt = 0; m_kcnt = 0;
  endfunction

  function automatic void model_comb(output dcache_req_i_t e_cache,
                                     output dcache_req_o_t e_cpu,
                                     output dcache_req_o_t e_pf);
    dcache_req_i_t src;
    bit open;
    e_cache = '0; e_cpu = '0; e_pf = '0; m_sel = 0;
    if (!rst_ni) begin
      e_cache.data_req      = cpu_req.data_req;
      e_cache.address_index = cpu_req.address_index;
      return;
    end
    open = !m_busy || cache_rsp.data_rvalid;
    if (open && cpu_req.data_req) m_sel = 1;
    else if (open && pf_req.data_req && m_idle >= IDLE_THRES) m_sel = 2;
    if (m_sel != 0) begin
      src = (m_sel == 1) ? cpu_req : pf_req;
      e_cache.address_index = src.address_index;
      e_cache.data_req      = 1'b1;
      e_cache.data_we       = (m_sel == 1) ? src.data_we : 1'b0;
      e_cache.data_be       = src.data_be;
      e_cache.data_size     = src.data_size;
      e_cache.data_wdata    = src.data_wdata;
    end
    if (m_busy) begin
      src = m_owner_pf ? pf_req : cpu_req;
      e_cache.address_tag = src.address_tag;
      e_cache.tag_valid   = src.tag_valid;
      e_cache.kill_req    = src.kill_req | kill_now();
      if (m_owner_pf) begin
        e_pf.data_rvalid = cache_rsp.data_rvalid;
        e_pf.data_rdata  = (m_killed || kill_now()) ? 32'd0 : cache_rsp.data_rdata;
      end else begin
        e_cpu.data_rvalid = cache_rsp.data_rvalid;
        e_cpu.data_rdata  = cache_rsp.data_rdata;
      end
    end
    e_cpu.data_gnt = cache_rsp.data_gnt && (m_sel == 1);
    e_pf.data_gnt  = cache_rsp.data_gnt && (m_sel == 2);
  endfunction

  function automatic void model_update();
    bit kn = kill_now();
    if (cpu_req.data_req || (m_busy && !m_owner_pf)) m_idle = 0;
    else if (m_idle < 255) m_idle++;
    if (kn && !m_killed) m_kcnt++;
    if (m_busy && cache_rsp.data_rvalid) m_killed = 0;
    else if (kn) m_killed = 1;
    if (cache_rsp.data_gnt && m_sel == 2) m_gcnt++;
    if (cache_rsp.data_gnt && m_sel != 0) begin
      m_busy = 1; m_owner_pf = (m_sel == 2);
    end else if (m_busy && cache_rsp.data_rvalid) begin
      m_busy = 0;
    end
  endfunction

  task automatic check_all();
    dcache_req_i_t e_cache;
    dcache_req_o_t e_cpu, e_pf;
    model_comb(e_cache, e_cpu, e_pf);
    chk("cache_req", cache_req, e_cache);
    chk("cpu_rsp", cpu_rsp, e_cpu);
    chk("pf_rsp", pf_rsp, e_pf);
    chk("pf_grant_cnt", pf_grant_cnt, m_gcnt);
    chk("pf_kill_cnt", pf_kill_cnt, m_kcnt);
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    if (rst_ni) model_update();
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    cpu_req = '0; pf_req = '0; cache_rsp = '0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_ni = 1'b0;
    m_reset();
    cycle();
    cycle();
    rst_ni = 1'b1;
  endtask

  function automatic dcache_req_i_t rand_req();
    logic [95:0] t = {$urandom(), $urandom(), $urandom()};
    return dcache_req_i_t'(t[$bits(dcache_req_i_t)-1:0]);
  endfunction

  initial begin
`ifdef DCACHE_ARB_PF_KILL_EN
    kill_exp = 1'b1;
`else
    kill_exp = 1'b0;
`endif
    do_reset();

    // CPU load: gnt same cycle, rvalid next cycle.
    cpu_req.data_req = 1; cpu_req.address_index = 12'h123; cpu_req.data_be = 4'hF;
    cache_rsp.data_gnt = 1;
    #1 chk("t1_cpu_gnt", cpu_rsp.data_gnt, 1'b1);
    cycle();
    cpu_req = '0; cpu_req.tag_valid = 1; cpu_req.address_tag = 20'hABCDE;
    cache_rsp = '0; cache_rsp.data_rvalid = 1; cache_rsp.data_rdata = 32'hDEAD_BEEF;
    #1 chk("t1_cpu_rdata", cpu_rsp.data_rdata, 32'hDEAD_BEEF);
    chk("t1_pf_silent", pf_rsp, '0);
    cycle();
    zero_inputs();
    #1 chk("t1_idle_tag", cache_req.tag_valid, 1'b0);
    cycle();

    // Prefetch held from reset: ineligible until IdleThres idle cycles have elapsed.
    do_reset();
    pf_req.data_req = 1; pf_req.address_index = 12'h0AA; pf_req.data_we = 1;
    cache_rsp.data_gnt = 1;
    for (int i = 0; i < IDLE_THRES; i++) begin
      #1 chk("t2_pf_gnt_early", pf_rsp.data_gnt, 1'b0);
      cycle();
    end
    #1 chk("t2_pf_gnt", pf_rsp.data_gnt, 1'b1);
    chk("t2_pf_we_forced", cache_req.data_we, 1'b0);
    cycle();
    chk("t2_grant_cnt", pf_grant_cnt, 32'd1);

    // PF owner, rvalid delayed 5 cycles, CPU arrives during the tag phase.
    pf_req = '0; pf_req.tag_valid = 1; pf_req.address_tag = 20'h55555;
    cpu_req.data_req = 1; cpu_req.address_index = 12'h200;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_cpu_wait", cpu_rsp.data_gnt, 1'b0);
      chk("t4_kill", cache_req.kill_req, kill_exp);
      cycle();
    end
    cache_rsp.data_rvalid = 1; cache_rsp.data_rdata = 32'h1234_5678;
    #1 chk("t4_cpu_gnt_rval", cpu_rsp.data_gnt, 1'b1);
    chk("t4_pf_rdata", pf_rsp.data_rdata, kill_exp ? 32'd0 : 32'h1234_5678);
    cycle();
    chk("t4_kill_cnt", pf_kill_cnt, {31'd0, kill_exp});

    // CPU back-to-back: second grant in the first rvalid cycle, no bubble.
    pf_req = '0;
    cpu_req.tag_valid = 1; cpu_req.address_tag = 20'h11111; cpu_req.address_index = 12'h201;
    cache_rsp.data_rdata = 32'hCAFE_0001;
    #1 chk("t5_cpu_gnt", cpu_rsp.data_gnt, 1'b1);
    cycle();
    cpu_req.data_req = 0; cpu_req.address_tag = 20'h22222;
    cache_rsp = '0;
    #1 chk("t5_tag_next", cache_req.address_tag, 20'h22222);
    chk("t5_tag_valid", cache_req.tag_valid, 1'b1);
    cycle();
    cache_rsp.data_rvalid = 1; cache_rsp.data_rdata = 32'hCAFE_0002;
    #1 chk("t5_rdata", cpu_rsp.data_rdata, 32'hCAFE_0002);
    cycle();
    zero_inputs();
    cycle();

    // Simultaneous requests with idle_cnt well above threshold: CPU wins.
    do_reset();
    for (int i = 0; i < 10; i++) cycle();
    cpu_req.data_req = 1; cpu_req.address_index = 12'h300;
    pf_req.data_req = 1; pf_req.address_index = 12'h0BB;
    cache_rsp.data_gnt = 1;
    #1 chk("t3_cpu_gnt", cpu_rsp.data_gnt, 1'b1);
    chk("t3_pf_gnt", pf_rsp.data_gnt, 1'b0);
    chk("t3_index", cache_req.address_index, 12'h300);
    cycle();
    cpu_req = '0; cpu_req.tag_valid = 1;
    cycle();
    cache_rsp.data_rvalid = 1;
    #1 chk("t3_pf_after_cpu", pf_rsp.data_gnt, 1'b0);
    cycle();
    zero_inputs();
    cycle();

    // Reset asserted in WAIT_RVAL; late rvalid after release is dropped.
    cpu_req.data_req = 1; cache_rsp.data_gnt = 1;
    cycle();
    cpu_req = '0; cpu_req.tag_valid = 1; cache_rsp = '0;
    cycle();
    cycle();
    cache_rsp.data_rvalid = 1; cache_rsp.data_rdata = 32'hBAD0_BAD0;
    rst_ni = 1'b0;
    m_reset();
    #1 chk("t6_rst_cache", cache_req, '0);
    chk("t6_rst_cpu", cpu_rsp, '0);
    cycle();
    rst_ni = 1'b1;
    #1 chk("t6_late_cpu", cpu_rsp.data_rvalid, 1'b0);
    chk("t6_late_pf", pf_rsp.data_rvalid, 1'b0);
    cycle();
    zero_inputs();
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cpu_req = rand_req();
      cpu_req.data_req = ($urandom_range(0, 3) == 0);
      pf_req = rand_req();
      pf_req.data_req = 1'($urandom_range(0, 1));
      cache_rsp.data_gnt    = ($urandom_range(0, 9) < 7);
      cache_rsp.data_rvalid = m_busy && ($urandom_range(0, 9) < 4);
      cache_rsp.data_rdata  = $urandom();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_load_arbiter.md
# dcache_load_arbiter

Two-requester arbiter sharing one write-through D-cache request port (`dcache_req_i_t`/`dcache_req_o_t`) between the CPU load unit and the stride prefetcher. Tracks each transaction through request, tag and response phases, routes grant/response to the owning requester, and admits prefetches only after sustained CPU idleness. Sits between the load unit / prefetcher and the wt_dcache load port; replaces any ad hoc port muxing.

## Interface
Parameters:
- `IdleThres`, 4: consecutive CPU-idle cycles required before a prefetch may be granted (1..255).

Ports:
- `clk` in 1: clock clk.
- `rst_ni` in 1: reset rst_ni, asynchronous, active-low.
- `cpu_req_i` in `dcache_req_i_t`: CPU load request/tag phase.
- `cpu_rsp_o` out `dcache_req_o_t`: gnt/rvalid/rdata to CPU.
- `pf_req_i` in `dcache_req_i_t`: prefetcher request/tag phase.
- `pf_rsp_o` out `dcache_req_o_t`: gnt/rvalid/rdata to prefetcher.
- `cache_req_o` out `dcache_req_i_t`: to D-cache port.
- `cache_rsp_i` in `dcache_req_o_t`: from D-cache port.
- `pf_grant_cnt_o` out 32: prefetch grants issued, wraps.
- `pf_kill_cnt_o` out 32: prefetches killed, wraps.

## Operation
- FSM `state` ∈ {IDLE, TAG, WAIT_RVAL}; register `owner` ∈ {CPU, PF}.
- Selection (combinational, only when state=IDLE or cache_rsp_i.data_rvalid=1): CPU if cpu data_req=1; else PF if pf data_req=1 and `idle_cnt >= IdleThres`; else none.
- Request fields (address_index, data_req, data_we, data_be, data_size, data_wdata) of cache_req_o come from selected requester; all zero if none. PF data_we forced 0.
- Tag fields (address_tag, tag_valid, kill_req) come from `owner` in TAG/WAIT_RVAL; zero in IDLE.
- cache_rsp_i.data_gnt forwarded only to selected requester; other sees 0.
- data_rvalid/data_rdata forwarded only to `owner` in TAG/WAIT_RVAL; non-owner sees rvalid=0, rdata=0.
- Transitions: IDLE→TAG on gnt (owner←selected). TAG: rvalid∧gnt→TAG (new owner); rvalid∧¬gnt→IDLE; ¬rvalid→WAIT_RVAL. WAIT_RVAL: same as TAG on rvalid; else hold.
- `idle_cnt` (8 bit): cleared when cpu data_req=1 or owner=CPU outside IDLE; else +1, saturates at 255.
- `pf_grant_cnt_o` +1 on every gnt forwarded to PF.
- Kill terminates a transaction only via rvalid; arbiter never ends a transaction without rvalid.

## Timing
- Grant path combinational: cpu data_req → cache data_req same cycle; cache gnt → requester gnt same cycle.
- Tag phase is exactly the cycle after gnt; owner's tag_valid forwarded from that cycle until rvalid.
- Back-to-back: new request may be granted in the rvalid cycle; next cycle is TAG for the new owner.
- CPU never preempts a granted PF transaction; worst-case extra CPU latency = one PF transaction.
- Simultaneous CPU and PF data_req: CPU wins always.
- PF data_req held while ineligible sees gnt=0; no state change.
- Reset (any time, incl. mid-transaction): state=IDLE, owner=CPU, idle_cnt=0, counters=0; all outputs zero except combinational pass-through of cpu data_req/index; in-flight response discarded.

## Configuration
- `DCACHE_ARB_PF_KILL_EN` defined: when owner=PF in TAG/WAIT_RVAL and cpu data_req=1, cache kill_req forced 1; `pf_kill_cnt_o` +1 once per killed transaction; PF still receives rvalid with rdata forced 0.
- Undefined: PF transactions run to completion untouched; `pf_kill_cnt_o` tied 0.

## Test plan
- CPU load, gnt same cycle, rvalid next cycle, rdata=0xDEAD_BEEF → cpu_rsp rvalid with 0xDEAD_BEEF; pf_rsp silent; state back to IDLE.
- PF data_req held, CPU idle 3 cycles, IdleThres=4 → no PF gnt; 4th idle cycle → PF gnt, pf_grant_cnt_o=1.
- CPU and PF request same cycle, idle_cnt=10 → CPU granted, idle_cnt=0, PF gnt=0.
- PF owner, rvalid delayed 5 cycles, CPU req arrives in TAG → CPU gnt only in rvalid cycle; with `DCACHE_ARB_PF_KILL_EN` kill_req=1 during wait, pf_kill_cnt_o=1.
- Two CPU loads back-to-back with gnt in rvalid cycle → second tag forwarded cycle after rvalid, no bubble.
- rst_ni low in WAIT_RVAL → outputs zero asynchronously; late rvalid after release not forwarded to either port.
